gate_exerciser: RTL and testbench

Self-checking stimulus driver for the combinational gate cells in this codebase, such as the inverter and the 2-input gates. It walks every input pattern onto a gate under test and waits a programmable settle time. It then samples the gate's output, compares it against a parameterised truth table, and reports a pass/fail verdict with a mismatch count. It lets gate cells be checked in-circuit or from a bench without hand-written per-gate stimulus.

---
 rtl/gate_test_pkg.sv | 17 +
 rtl/gate_exerciser_if.sv | 23 ++
 rtl/gate_exerciser_settle_timer.sv | 26 ++
 rtl/gate_exerciser.sv | 120 ++++++++++++
 tb/tb_gate_exerciser.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and truth-table constants for the gate-cell exerciser.
package gate_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // TRUTH[i] is the expected gate output for input pattern i
    localparam logic [1:0] TT_NOT  = 2'b01;
    localparam logic [3:0] TT_AND2 = 4'b1000;
    localparam logic [3:0] TT_OR2  = 4'b1110;
    localparam logic [3:0] TT_XOR2 = 4'b0110;

endpackage

// File: rtl/gate_exerciser_if.sv
// Stimulus/response and result signals between the exerciser and its gate/host.
interface gate_exerciser_if #(
    parameter int unsigned N_IN = 1
);
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN-1:0]   stim;
    logic              resp;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_fail_idx;

    modport master (
        input  start, resp,
        output busy, done, pass, stim, err_count, first_fail_idx
    );

    modport slave (
        output start, resp,
        input  busy, done, pass, stim, err_count, first_fail_idx
    );
endinterface

// File: rtl/gate_exerciser_settle_timer.sv
// Settle timer: clears on load, counts up while enabled, flags when TERM is reached.
module settle_timer #(
    parameter int unsigned TERM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc_c
);
    localparam int unsigned W = (TERM < 1) ? 1 : $clog2(TERM + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc_c = (count == W'(TERM));
endmodule

// File: rtl/gate_exerciser.sv
// Walks every input pattern onto a gate under test, samples it after a settle
// time and scores the responses against a truth table.
module gate_exerciser
    import gate_test_pkg::*;
#(
    parameter int unsigned          N_IN   = 1,
    parameter int unsigned          SETTLE = 2,
    parameter logic [2**N_IN-1:0]   TRUTH  = TT_NOT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_exerciser_if.master     bus
);
    localparam int unsigned CW = N_IN + 1;

    state_e            state, state_nx;
    logic [N_IN-1:0]   stim, stim_nx;
    logic              busy, busy_nx;
    logic              done, done_nx;
    logic              pass, pass_nx;
    logic [CW-1:0]     err_count, err_nx;
    logic [N_IN-1:0]   first_fail, first_fail_nx;
    logic              tmr_load, tmr_en, tmr_tc_c;

    settle_timer #(
        .TERM (SETTLE - 1)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .en    (tmr_en),
        .tc_c  (tmr_tc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            state      <= state_nx;
            stim       <= stim_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            pass       <= pass_nx;
            err_count  <= err_nx;
            first_fail <= first_fail_nx;
        end
    end

    // Next-state and next-output logic; the pattern counter and comparator live here
    always_comb begin
        state_nx      = state;
        stim_nx       = stim;
        busy_nx       = busy;
        done_nx       = 1'b0;
        pass_nx       = pass;
        err_nx        = err_count;
        first_fail_nx = first_fail;
        tmr_load      = 1'b0;
        tmr_en        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx      = ST_DRIVE;
                    busy_nx       = 1'b1;
                    stim_nx       = '0;
                    pass_nx       = 1'b0;
                    err_nx        = '0;
                    first_fail_nx = '0;
                    tmr_load      = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (tmr_tc_c) begin
                    state_nx = ST_SAMPLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (bus.resp != TRUTH[stim]) begin
                    err_nx = err_count + CW'(1);
                    if (err_count == '0) begin
                        first_fail_nx = stim;
                    end
                end
                if (stim == '1) begin
                    state_nx = ST_DONE;
                    done_nx  = 1'b1;
                    pass_nx  = (err_nx == '0);
                end else begin
                    state_nx = ST_DRIVE;
                    stim_nx  = stim + N_IN'(1);
                    tmr_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                busy_nx  = 1'b0;
                stim_nx  = '0;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus.stim           = stim;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = pass;
    assign bus.err_count      = err_count;
    assign bus.first_fail_idx = first_fail;
endmodule

// File: tb/tb_gate_exerciser.sv
// Randomized self-checking bench: three exerciser configurations scored against a
// pattern-level reference model of the expected run timeline and verdict.
module tb_gate_exerciser;
    import gate_test_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_exerciser_if #(.N_IN(1)) bus0 ();
    gate_exerciser_if #(.N_IN(2)) bus1 ();
    gate_exerciser_if #(.N_IN(3)) bus2 ();

    gate_exerciser #(.N_IN(1), .SETTLE(2), .TRUTH(TT_NOT))  u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    gate_exerciser #(.N_IN(2), .SETTLE(2), .TRUTH(TT_AND2)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    gate_exerciser #(.N_IN(3), .SETTLE(1), .TRUTH(8'h96))   u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int unsigned  n_in_p   [3];
    int unsigned  settle_p [3];
    logic [15:0]  truth_p  [3];
    logic         start_w  [3];
    logic [15:0]  tab      [3];
    int           prev_done[3];
    bit           prev_hold[3];

    logic [3:0] stim_o [3];
    logic [4:0] err_o  [3];
    logic [3:0] ffi_o  [3];
    logic       busy_o [3];
    logic       done_o [3];
    logic       pass_o [3];

    // Each gate under test is a lookup of its own behaviour table
    assign bus0.start = start_w[0];
    assign bus1.start = start_w[1];
    assign bus2.start = start_w[2];
    assign bus0.resp  = tab[0][bus0.stim];
    assign bus1.resp  = tab[1][bus1.stim];
    assign bus2.resp  = tab[2][bus2.stim];

    assign stim_o[0] = 4'(bus0.stim);  assign err_o[0] = 5'(bus0.err_count);  assign ffi_o[0] = 4'(bus0.first_fail_idx);
    assign stim_o[1] = 4'(bus1.stim);  assign err_o[1] = 5'(bus1.err_count);  assign ffi_o[1] = 4'(bus1.first_fail_idx);
    assign stim_o[2] = 4'(bus2.stim);  assign err_o[2] = 5'(bus2.err_count);  assign ffi_o[2] = 4'(bus2.first_fail_idx);
    assign busy_o[0] = bus0.busy;  assign done_o[0] = bus0.done;  assign pass_o[0] = bus0.pass;
    assign busy_o[1] = bus1.busy;  assign done_o[1] = bus1.done;  assign pass_o[1] = bus1.pass;
    assign busy_o[2] = bus2.busy;  assign done_o[2] = bus2.done;  assign pass_o[2] = bus2.pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference verdict: count of patterns where the gate disagrees with the table
    function automatic void model(input logic [15:0] t, input logic [15:0] tt, input int p,
                                  output int e, output int f);
        e = 0;
        f = 0;
        for (int i = 0; i < p; i++) begin
            if (t[i] !== tt[i]) begin
                if (e == 0) f = i;
                e++;
            end
        end
    endfunction

    task automatic check_zero(input int d, input string tag);
        check($sformatf("%s d%0d stim", tag, d), 32'(stim_o[d]), 0);
        check($sformatf("%s d%0d busy", tag, d), 32'(busy_o[d]), 0);
        check($sformatf("%s d%0d done", tag, d), 32'(done_o[d]), 0);
        check($sformatf("%s d%0d pass", tag, d), 32'(pass_o[d]), 0);
        check($sformatf("%s d%0d err",  tag, d), 32'(err_o[d]),  0);
        check($sformatf("%s d%0d ffi",  tag, d), 32'(ffi_o[d]),  0);
    endtask

    // One full run, entered and left at a falling edge with the DUT idle
    task automatic run(input int d, input logic [15:0] t, input bit hold, input bit poke);
        int p, s, len, e, f;
        p   = 1 << n_in_p[d];
        s   = int'(settle_p[d]);
        len = p * (s + 1);
        model(t, truth_p[d], p, e, f);
        tab[d]     = t;
        start_w[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int j = 1; j <= len; j++) begin
            if (j == 1 && !hold) start_w[d] = 1'b0;
            if (poke && j == s + 2) start_w[d] = 1'b1;
            if (poke && j == s + 3 && !hold) start_w[d] = 1'b0;
            check($sformatf("d%0d stim c%0d", d, j), 32'(stim_o[d]), 32'((j - 1) / (s + 1)));
            check($sformatf("d%0d busy c%0d", d, j), 32'(busy_o[d]), 1);
            check($sformatf("d%0d done c%0d", d, j), 32'(done_o[d]), 0);
            @(negedge clk);
        end
        check($sformatf("d%0d done", d),     32'(done_o[d]), 1);
        check($sformatf("d%0d busy@done", d), 32'(busy_o[d]), 1);
        check($sformatf("d%0d err", d),      32'(err_o[d]),  32'(e));
        check($sformatf("d%0d pass", d),     32'(pass_o[d]), 32'(e == 0));
        if (e != 0) check($sformatf("d%0d ffi", d), 32'(ffi_o[d]), 32'(f));
        if (hold && prev_hold[d]) check($sformatf("d%0d done gap", d), 32'(cyc - prev_done[d]), 32'(len + 2));
        prev_done[d] = cyc;
        prev_hold[d] = hold;
        @(negedge clk);
        check($sformatf("d%0d idle done", d), 32'(done_o[d]), 0);
        check($sformatf("d%0d idle busy", d), 32'(busy_o[d]), 0);
        check($sformatf("d%0d idle stim", d), 32'(stim_o[d]), 0);
        check($sformatf("d%0d hold err", d),  32'(err_o[d]),  32'(e));
        check($sformatf("d%0d hold pass", d), 32'(pass_o[d]), 32'(e == 0));
        if (e != 0) check($sformatf("d%0d hold ffi", d), 32'(ffi_o[d]), 32'(f));
    endtask

    // Abort a run with reset at cycle 'at' after acceptance, then rerun cleanly
    task automatic reset_mid(input int d, input logic [15:0] t, input int at);
        tab[d]     = t;
        start_w[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_w[d] = 1'b0;
        for (int j = 1; j < at; j++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero(d, "rst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst d%0d no done %0d", d, k), 32'(done_o[d]), 0);
            check($sformatf("rst d%0d no busy %0d", d, k), 32'(busy_o[d]), 0);
        end
        rst_n = 1'b1;
        prev_hold[d] = 1'b0;
        run(d, truth_p[d], 1'b0, 1'b0);
    endtask

    initial begin
        int d;
        n_in_p   = '{1, 2, 3};
        settle_p = '{2, 2, 1};
        truth_p  = '{16'(TT_NOT), 16'(TT_AND2), 16'h0096};
        for (int i = 0; i < 3; i++) begin
            start_w[i]   = 1'b0;
            tab[i]       = truth_p[i];
            prev_done[i] = 0;
            prev_hold[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_zero(i, "reset");
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 16'(TT_NOT), 1'b0, 1'b0);
        run(0, 16'h0000, 1'b0, 1'b0);
        run(1, 16'(TT_OR2), 1'b0, 1'b0);
        run(1, 16'(TT_OR2), 1'b0, 1'b1);
        run(0, 16'(TT_NOT), 1'b0, 1'b1);

        reset_mid(0, 16'(TT_NOT), 3);
        reset_mid(1, 16'(TT_OR2), 7);

        for (int k = 0; k < 3; k++) run(0, 16'(TT_NOT), 1'b1, 1'b0);
        start_w[0] = 1'b0;
        prev_hold[0] = 1'b0;
        @(negedge clk);

        run(2, 16'h0096, 1'b0, 1'b0);
        run(2, 16'h0069, 1'b0, 1'b0);

        for (int k = 0; k < 14; k++) begin
            d = int'($urandom_range(0, 2));
            run(d, 16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
